// File: rtl/aes_inv_columns_mixer_serial.sv
// rtl/aes_inv_columns_mixer_serial.sv - column-serial InvMixColumns engine with valid/ready handshakes
// Column c lives in bits [127-32c -: 32]; one working register is mixed in place and drives out_block_o.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_inv_columns_mixer_serial #(
  parameter int COLUMNS_PER_CYCLE = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [`AES_BLOCK_SIZE-1:0] in_block_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [`AES_BLOCK_SIZE-1:0] out_block_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MIX  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A step of 4 truncates to 0, so the single-group case stays on column 0.
  localparam logic [1:0] COL_STEP = 2'(COLUMNS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLUMNS_PER_CYCLE);

  if (COLUMNS_PER_CYCLE != 1 && COLUMNS_PER_CYCLE != 2 && COLUMNS_PER_CYCLE != 4) begin : g_bad_param
    $error("COLUMNS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [1:0]                 state_q, state_d;
  logic [1:0]                 col_q, col_d;
  logic [`AES_BLOCK_SIZE-1:0] data_q, data_d;
  logic [`AES_BLOCK_SIZE-1:0] mixed;
  logic [1:0]                 mix_idx;
  logic                       accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = gmul(a[i], 4'he) ^ gmul(a[(i+1)%4], 4'hb)
                  ^ gmul(a[(i+2)%4], 4'hd) ^ gmul(a[(i+3)%4], 4'h9);
    end
    return r;
  endfunction

  always_comb begin
    mixed   = data_q;
    mix_idx = '0;
    for (int k = 0; k < COLUMNS_PER_CYCLE; k++) begin
      mix_idx = col_q + 2'(k);
      mixed[(3 - int'(mix_idx))*32 +: 32] = inv_mix_col(data_q[(3 - int'(mix_idx))*32 +: 32]);
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == S_DONE);
  assign out_block_o = data_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_MIX;
          col_d   = '0;
          data_d  = in_block_i;
        end
      end
      S_MIX: begin
        data_d = mixed;
        col_d  = col_q + COL_STEP;
        if (col_q == LAST_COL) state_d = S_DONE;
      end
      S_DONE: begin
        // Output handshake and next input accept share the same edge.
        if (out_ready_i) begin
          if (accept) begin
            state_d = S_MIX;
            col_d   = '0;
            data_d  = in_block_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_columns_mixer_serial.sv
// tb/tb_aes_inv_columns_mixer_serial.sv - directed and round-trip bench for aes_inv_columns_mixer_serial
// Three instances run COLUMNS_PER_CYCLE = 1, 2, 4 (unit u uses 1<<u).
module tb_aes_inv_columns_mixer_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_block  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_block [3];

  int checks = 0;
  int failures = 0;

  logic [31:0] vin  [4] = '{32'hbca14d8e, 32'h9d58dc9f, 32'hd6d7d5d5, 32'h01010101};
  logic [31:0] vexp [4] = '{32'h455313db, 32'h5c220af2, 32'hd5d4d4d4, 32'h01010101};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_columns_mixer_serial #(.COLUMNS_PER_CYCLE(1 << g)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .in_block_i  (in_block[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .out_block_o (out_block[g])
    );
  end

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns {02 03 01 01}: the DUT must undo this.
  function automatic logic [127:0] fwd_mix(input logic [127:0] blk);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = blk[32*c + 8*i +: 8];
      for (int i = 0; i < 4; i++) begin
        r[32*c + 8*i +: 8] = tb_xtime(a[i]) ^ (tb_xtime(a[(i+1)%4]) ^ a[(i+1)%4])
                           ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      in_block[u] = '0;
      out_ready[u] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (out_valid[u] !== 1'b0) begin failures++; $display("FAIL reset_out_valid u%0d got=%b exp=0", u, out_valid[u]); end
      checks++;
      if (out_block[u] !== 128'h0) begin failures++; $display("FAIL reset_out_block u%0d got=%h exp=0", u, out_block[u]); end
      checks++;
      if (in_ready[u] !== 1'b1) begin failures++; $display("FAIL reset_in_ready u%0d got=%b exp=1", u, in_ready[u]); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Push one block into unit u, check latency (4>>u) and the result, then drain it.
  task automatic run_block(input int u, input logic [127:0] blk, input logic [127:0] exp, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_block[u] = blk;
    out_ready[u] = 1'b0;
    #1;
    checks++;
    if (in_ready[u] !== 1'b1) begin failures++; $display("FAIL %s_in_ready u%0d got=%b exp=1", name, u, in_ready[u]); end
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_block[u] = ~blk;
    seen = 1'b0;
    lat = 0;
    if (out_valid[u] !== 1'b1) begin
      for (lat = 1; lat <= 20; lat++) begin
        @(negedge clk);
        if (out_valid[u] === 1'b1) begin seen = 1'b1; break; end
      end
    end
    checks++;
    if (!seen || lat != (4 >> u)) begin
      failures++;
      $display("FAIL %s_latency u%0d got=%0d exp=%0d", name, u, seen ? lat : -1, 4 >> u);
    end
    checks++;
    if (out_block[u] !== exp) begin failures++; $display("FAIL %s_data u%0d got=%h exp=%h", name, u, out_block[u], exp); end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    checks++;
    if (out_valid[u] !== 1'b0) begin failures++; $display("FAIL %s_drain u%0d got=%b exp=0", name, u, out_valid[u]); end
  endtask

  task automatic test_single();
    for (int u = 0; u < 3; u++)
      run_block(u, {4{vin[0]}}, {4{vexp[0]}}, "single");
  endtask

  task automatic test_columns();
    logic [127:0] blk, exp;
    for (int u = 0; u < 3; u++) begin
      for (int rot = 0; rot < 4; rot++) begin
        for (int c = 0; c < 4; c++) begin
          blk[127 - 32*c -: 32] = vin[(c + rot) % 4];
          exp[127 - 32*c -: 32] = vexp[(c + rot) % 4];
        end
        run_block(u, blk, exp, "columns");
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    logic [127:0] exp_a;
    exp_a = {vexp[1], vexp[0], vexp[3], vexp[2]};
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_block[0] = {vin[1], vin[0], vin[3], vin[2]};
    out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_block[0] = {4{vin[2]}};
      #1;
      checks++;
      if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", i, out_valid[0]); end
      checks++;
      if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready[0]); end
      checks++;
      if (out_block[0] !== exp_a) begin failures++; $display("FAIL bp_hold cyc%0d got=%h exp=%h", i, out_block[0], exp_a); end
      @(negedge clk);
    end
    in_valid[0] = 1'b1;
    in_block[0] = {4{vin[1]}};
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready[0]); end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || lat != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", seen ? lat : -1); end
    checks++;
    if (out_block[0] !== {4{vexp[1]}}) begin failures++; $display("FAIL b2b_data got=%h exp=%h", out_block[0], {4{vexp[1]}}); end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_mix();
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_block[0] = {4{vin[1]}};
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_block[0] === 128'h0) begin failures++; $display("FAIL midmix_partial got=%h exp=nonzero", out_block[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid[0]); end
    checks++;
    if (out_block[0] !== 128'h0) begin failures++; $display("FAIL midrst_out_block got=%h exp=0", out_block[0]); end
    checks++;
    if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, {4{vin[0]}}, {4{vexp[0]}}, "after_reset");
  endtask

  // Streams forward-mixed random blocks; expects the originals back, in order.
  task automatic stream(input int u, input int n, input bit rnd, input int period);
    logic [127:0] orig [$];
    int ni, no, cyc, last_cyc, limit;
    bit acc;
    for (int i = 0; i < n; i++) orig.push_back({$urandom, $urandom, $urandom, $urandom});
    ni = 0; no = 0; cyc = 0; last_cyc = 0; acc = 1'b0;
    limit = n * 20 + 100;
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b0;
    while (no < n && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (acc) begin ni++; in_valid[u] = 1'b0; acc = 1'b0; end
      if (!in_valid[u] && ni < n && (!rnd || $urandom_range(0, 2) != 0)) begin
        in_valid[u] = 1'b1;
        in_block[u] = fwd_mix(orig[ni]);
      end
      out_ready[u] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (in_valid[u] && in_ready[u]) acc = 1'b1;
      if (out_valid[u] && out_ready[u]) begin
        checks++;
        if (out_block[u] !== orig[no]) begin
          failures++;
          $display("FAIL stream_data u%0d blk%0d got=%h exp=%h", u, no, out_block[u], orig[no]);
        end
        if (period > 0 && no > 0) begin
          checks++;
          if (cyc - last_cyc != period) begin
            failures++;
            $display("FAIL stream_period u%0d blk%0d got=%0d exp=%0d", u, no, cyc - last_cyc, period);
          end
        end
        last_cyc = cyc;
        no++;
      end
      @(posedge clk);
    end
    checks++;
    if (no != n) begin failures++; $display("FAIL stream_count u%0d got=%0d exp=%0d", u, no, n); end
    @(negedge clk);
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b0;
  endtask

  task automatic test_throughput();
    for (int u = 0; u < 3; u++) stream(u, 8, 1'b0, (4 >> u) + 1);
  endtask

  task automatic test_round_trip();
    stream(0, 1000, 1'b1, 0);
    stream(1, 200, 1'b1, 0);
    stream(2, 200, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_columns();
    test_backpressure();
    test_reset_mid_mix();
    test_throughput();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_columns_mixer_serial.md
# aes_inv_columns_mixer_serial

Sequential, column-serial InvMixColumns engine with valid/ready handshakes on both sides, used in the iterative AES decryption datapath. It accepts one 128-bit state and applies the GF(2^8) inverse matrix {0E 0B 0D 09} to each 32-bit column over 4/COLUMNS_PER_CYCLE cycles. It delivers the result through a holding output stage. It trades the area of four parallel inverse matrices for latency, and is the decrypt-only, multi-cycle counterpart of the combinational columns mixer.

## Interface
- COLUMNS_PER_CYCLE, 1, number of columns transformed per MIX cycle; legal values 1, 2, 4; any other value is an elaboration error.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- In_valid  input  1  upstream block present on In_block.
- In_ready  output  1  block engine can accept In_block this cycle.
- In_block  input  `AES_BLOCK_SIZE  state to be inverse-mixed.
- Out_valid  output  1  Out_block holds a finished result.
- Out_ready  input  1  downstream accepts Out_block this cycle.
- Out_block  output  `AES_BLOCK_SIZE  result; meaningful only while Out_valid=1.

## Operation
- Column c (0..3) occupies the `AES_1ST_WORD..`AES_4TH_WORD field of the block. Byte row r (0..3) of a column is at bits [8r+7:8r] of that word.
- Per column, out row r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3), with indices mod 4 and multiplication in GF(2^8) mod 0x11B. xtime is a left shift with conditional XOR of 0x1B when bit 7 is set.
- One 128-bit working register drives Out_block directly. A column counter col is 2 bits wide and steps by COLUMNS_PER_CYCLE, wrapping to 0.
- States:
  - IDLE: In_ready=1.
  - MIX: In_ready=0, Out_valid=0.
  - DONE: Out_valid=1; In_ready=Out_ready.
- Transitions:
  - IDLE→MIX on In_valid. In_block is loaded into the working register and col=0.
  - MIX: each cycle, columns col..col+COLUMNS_PER_CYCLE-1 of the working register are replaced by their inverse-mixed values, and col advances. When the last column group is written, MIX→DONE.
  - DONE, Out_ready=0: hold. Out_block and Out_valid are stable, and no input is accepted.
  - DONE, Out_ready=1, In_valid=0: →IDLE.
  - DONE, Out_ready=1, In_valid=1: the output handshake and the input accept occur in the same edge. The new block is loaded, col=0, and the state goes →MIX.
- In_valid and In_block are ignored whenever In_ready=0. The upstream block is not consumed until the handshake edge.
- Columns not yet processed are never modified. Each column is transformed exactly once per block.

## Timing
- Reset (Rst_n=0, asynchronous assert): state=IDLE, col=0, working register=0.
  - Outputs: Out_valid=0, Out_block=0, In_ready=1.
  - Deassertion is sampled synchronously.
- Reset asserted mid-MIX or in DONE aborts the block immediately. Nothing is emitted, and the partial result is cleared.
- Latency: Out_valid rises 4/COLUMNS_PER_CYCLE cycles after the accept edge (4, 2 or 1).
- Throughput: one block per 4/COLUMNS_PER_CYCLE+1 cycles at sustained Out_ready=1, using the DONE-to-MIX overlap.
- In_ready is combinational from state and Out_ready only. Out_valid and Out_block are registered.

## Test plan
- Single vector: all four columns = 32'hbca14d8e (rows 8e 4d a1 bc). Required: all columns = 32'h455313db. Out_valid rises exactly 4 cycles after the accept edge at COLUMNS_PER_CYCLE=1.
- Column ordering, each column independent:
  - 32'hbca14d8e → 32'h455313db
  - 32'h9d58dc9f → 32'h5c220af2
  - 32'hd6d7d5d5 → 32'hd5d4d4d4
  - 32'h01010101 → 32'h01010101
  - Repeat the set rotated through all four column positions.
- Backpressure: hold Out_ready=0 for 10 cycles in DONE. Out_block stays constant, Out_valid=1, In_ready=0, and In_valid pulses are ignored. Then raise Out_ready together with In_valid: a back-to-back accept occurs, and the next Out_valid comes 4 cycles later with the correct data.
- Reset mid-MIX at col=2: Out_valid=0, Out_block=0 and In_ready=1 immediately (asynchronous). After release, a fresh 32'hbca14d8e block yields 32'h455313db with normal latency.
- Parameter sweep COLUMNS_PER_CYCLE=2 and 4: the same vectors give the same data with latencies 2 and 1. Sustained streaming gives throughput 1/3 and 1/2 blocks per cycle.
- Random round trip: 1000 random blocks are first passed through the forward MixColumns model and then through the DUT with random Out_ready and In_valid gaps. Every output equals the original block, in order, with no drops or duplicates.
